// File: rtl/pa_cp0_cache_seq_pkg.sv
// Shared definitions for the CP0 cache-maintenance sequencer and the IDU
// custom-extension decoder: sequencer state encodings, D-cache request type
// codes, cache-op field encodings and the op decode helper.
package pa_cp0_cache_seq_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StDcAll = 3'd1,
        StDcOne = 3'd2,
        StIc    = 3'd3,
        StWait  = 3'd4,
        StCmplt = 3'd5
    } seq_state_e;

    // D-cache request type codes; 2'b00 never appears on the request bus.
    localparam logic [1:0] REQ_CLR    = 2'b01;
    localparam logic [1:0] REQ_INV    = 2'b10;
    localparam logic [1:0] REQ_CLRINV = 2'b11;

    // Op = {inst[25], inst[24:20]}. The D-cache groups are matched on op[4:2],
    // with op[5] selecting all (0) versus set/way or PA (1).
    localparam logic [2:0] OP_DC_ALL = 3'b000;  // op[5]=0
    localparam logic [2:0] OP_DC_SW  = 3'b000;  // op[5]=1
    localparam logic [2:0] OP_DC_PA  = 3'b010;  // op[5]=1
    localparam logic [3:0] OP_IC_ALL = 4'b1000; // op[5]=0, op[4:1]
    localparam logic [5:0] OP_IC_PA  = 6'b111000;

    typedef enum logic [1:0] {
        AddrZero   = 2'd0,
        AddrRs1    = 2'd1,
        AddrSetWay = 2'd2
    } addr_src_e;

    typedef struct packed {
        seq_state_e nxt_state;
        logic [1:0] req_type;
        logic       pa;
        addr_src_e  addr_src;
    } op_dec_t;

    // Anything not recognised as a cache op completes as a no-op.
    function automatic op_dec_t decode_op(input logic [5:0] op);
        op_dec_t d;
        d = '{nxt_state: StCmplt, req_type: 2'b00, pa: 1'b0, addr_src: AddrZero};
        if (!op[5] && op[4:2] == OP_DC_ALL && op[1:0] != 2'b00) begin
            d = '{nxt_state: StDcAll, req_type: op[1:0], pa: 1'b0, addr_src: AddrZero};
        end else if (op[5] && op[4:2] == OP_DC_SW && op[1:0] != 2'b00) begin
            d = '{nxt_state: StDcOne, req_type: op[1:0], pa: 1'b0, addr_src: AddrSetWay};
        end else if (op[5] && op[4:2] == OP_DC_PA && op[1:0] != 2'b00) begin
            d = '{nxt_state: StDcOne, req_type: op[1:0], pa: 1'b1, addr_src: AddrRs1};
        end else if (!op[5] && op[4:1] == OP_IC_ALL) begin
            d = '{nxt_state: StIc, req_type: 2'b00, pa: 1'b0, addr_src: AddrZero};
        end else if (op == OP_IC_PA) begin
            d = '{nxt_state: StIc, req_type: 2'b00, pa: 1'b1, addr_src: AddrRs1};
        end
        return d;
    endfunction

endpackage

// File: rtl/pa_cp0_cache_seq_cnt.sv
// Set/way walk counter for the "all" D-cache ops. Way is the inner loop.
// Ports:
//   forever_cpuclk, cpurst_b : clock, synchronous active-low reset
//   cnt_clr                  : return to set 0, way 0 (has priority over cnt_adv)
//   cnt_adv                  : step to the next line
//   cnt_set, cnt_way         : current line
//   cnt_last                 : current line is set 2^SET_W-1, way WAY_NUM-1
module pa_cp0_cache_seq_cnt #(
    parameter int unsigned SET_W   = 7,
    parameter int unsigned WAY_NUM = 2,
    parameter int unsigned WAY_W   = 1
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst_b,
    input  logic             cnt_clr,
    input  logic             cnt_adv,
    output logic [SET_W-1:0] cnt_set,
    output logic [WAY_W-1:0] cnt_way,
    output logic             cnt_last
);

    logic [SET_W-1:0] set_q;
    logic [WAY_W-1:0] way_q;
    logic             way_last;

    assign way_last = (way_q == WAY_W'(WAY_NUM - 1));
    assign cnt_last = way_last && (&set_q);
    assign cnt_set  = set_q;
    assign cnt_way  = way_q;

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            set_q <= '0;
            way_q <= '0;
        end else if (cnt_clr) begin
            set_q <= '0;
            way_q <= '0;
        end else if (cnt_adv) begin
            if (way_last) begin
                way_q <= '0;
                set_q <= set_q + SET_W'(1);
            end else begin
                way_q <= way_q + WAY_W'(1);
            end
        end
    end

endmodule

// File: rtl/pa_cp0_cache_seq.sv
// CP0 cache-maintenance sequencer. Accepts one decoded cache op from the IDU,
// issues D-cache line requests (single line or a full set/way walk) or one
// I-cache invalidate, waits for the cache to drain and pulses completion to
// the RTU. Non-cache ops complete immediately.
// Ports:
//   forever_cpuclk, cpurst_b     : clock, synchronous active-low reset
//   idu_cp0_cache_vld/op/rs1     : op in; accepted when cp0_idu_cache_rdy
//   cp0_idu_cache_rdy            : idle
//   cp0_dcache_req_*             : D-cache line request, held until dcache_cp0_req_gnt
//   dcache_cp0_idle              : D-cache has retired all line ops
//   cp0_icache_inv_req/inv_pa    : I-cache invalidate (level) until icache_cp0_inv_done
//   cp0_rtu_cache_cmplt          : one-cycle completion pulse
module pa_cp0_cache_seq
    import pa_cp0_cache_seq_pkg::*;
#(
    parameter int unsigned SET_W    = 7,
    parameter int unsigned WAY_NUM  = 2,
    parameter int unsigned LINE_OFF = 4
) (
    input  logic        forever_cpuclk,
    input  logic        cpurst_b,
    input  logic        idu_cp0_cache_vld,
    input  logic [5:0]  idu_cp0_cache_op,
    input  logic [31:0] idu_cp0_cache_rs1,
    output logic        cp0_idu_cache_rdy,
    output logic        cp0_dcache_req_vld,
    output logic [1:0]  cp0_dcache_req_type,
    output logic        cp0_dcache_req_pa,
    output logic [31:0] cp0_dcache_req_addr,
    input  logic        dcache_cp0_req_gnt,
    input  logic        dcache_cp0_idle,
    output logic        cp0_icache_inv_req,
    output logic        cp0_icache_inv_pa,
    input  logic        icache_cp0_inv_done,
    output logic        cp0_rtu_cache_cmplt
);

    localparam int unsigned WAY_W = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;

    seq_state_e       state_q, state_d;
    logic [1:0]       type_q, type_d;
    logic             pa_q, pa_d;
    logic [31:0]      addr_q, addr_d;
    op_dec_t          op_dec;
    logic             cnt_clr, cnt_adv, cnt_last;
    logic [SET_W-1:0] cnt_set;
    logic [WAY_W-1:0] cnt_way;

    // Set/way address: way in the top bits, set in the set-index field.
    function automatic logic [31:0] sw_addr(input logic [WAY_W-1:0] way,
                                            input logic [SET_W-1:0] set);
        logic [31:0] a;
        a = '0;
        a[31 -: WAY_W]     = way;
        a[LINE_OFF +: SET_W] = set;
        return a;
    endfunction

    assign op_dec = decode_op(idu_cp0_cache_op);

    pa_cp0_cache_seq_cnt #(
        .SET_W   (SET_W),
        .WAY_NUM (WAY_NUM),
        .WAY_W   (WAY_W)
    ) u_cnt (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .cnt_clr        (cnt_clr),
        .cnt_adv        (cnt_adv),
        .cnt_set        (cnt_set),
        .cnt_way        (cnt_way),
        .cnt_last       (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        pa_d    = pa_q;
        addr_d  = addr_q;
        cnt_clr = 1'b0;
        cnt_adv = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (idu_cp0_cache_vld) begin
                    state_d = op_dec.nxt_state;
                    type_d  = op_dec.req_type;
                    pa_d    = op_dec.pa;
                    cnt_clr = 1'b1;
                    unique case (op_dec.addr_src)
                        AddrRs1:    addr_d = idu_cp0_cache_rs1;
                        AddrSetWay: addr_d = sw_addr(idu_cp0_cache_rs1[31 -: WAY_W],
                                                     idu_cp0_cache_rs1[LINE_OFF +: SET_W]);
                        default:    addr_d = '0;
                    endcase
                end
            end
            StDcAll: begin
                if (dcache_cp0_req_gnt) begin
                    cnt_adv = 1'b1;
                    if (cnt_last) state_d = StWait;
                end
            end
            StDcOne: if (dcache_cp0_req_gnt) state_d = StWait;
            StIc:    if (icache_cp0_inv_done) state_d = StCmplt;
            StWait:  if (dcache_cp0_idle) state_d = StCmplt;
            StCmplt: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state_q <= StIdle;
            type_q  <= 2'b00;
            pa_q    <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            pa_q    <= pa_d;
            addr_q  <= addr_d;
        end
    end

    // Outputs are gated by state so stale op registers never leak out.
    always_comb begin
        cp0_idu_cache_rdy   = (state_q == StIdle);
        cp0_dcache_req_vld  = (state_q == StDcAll) || (state_q == StDcOne);
        cp0_dcache_req_type = cp0_dcache_req_vld ? type_q : 2'b00;
        cp0_dcache_req_pa   = (state_q == StDcOne) && pa_q;
        cp0_dcache_req_addr = '0;
        if (state_q == StDcAll) begin
            cp0_dcache_req_addr = sw_addr(cnt_way, cnt_set);
        end else if (state_q == StDcOne || state_q == StIc) begin
            cp0_dcache_req_addr = addr_q;
        end
        cp0_icache_inv_req  = (state_q == StIc);
        cp0_icache_inv_pa   = (state_q == StIc) && pa_q;
        cp0_rtu_cache_cmplt = (state_q == StCmplt);
    end

endmodule

// File: tb/tb_pa_cp0_cache_seq.sv
module tb_pa_cp0_cache_seq;

    localparam int SET_W    = 2;
    localparam int WAY_NUM  = 2;
    localparam int LINE_OFF = 4;
    localparam logic [39:0] EXP_RST = {1'b1, 39'd0};

    logic        clk = 1'b0;
    logic        rst_b;
    logic        vld;
    logic [5:0]  op;
    logic [31:0] rs1;
    logic        rdy, req_vld, req_pa, gnt, idle, inv_req, inv_pa, done, cmplt;
    logic [1:0]  req_type;
    logic [31:0] req_addr;

    typedef struct packed {
        logic [1:0]  t;
        logic        pa;
        logic [31:0] a;
    } req_t;

    req_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_cmplt = 0;
    int   cmplt_cyc = 0;
    int   cyc = 0;

    pa_cp0_cache_seq #(
        .SET_W    (SET_W),
        .WAY_NUM  (WAY_NUM),
        .LINE_OFF (LINE_OFF)
    ) dut (
        .forever_cpuclk      (clk),
        .cpurst_b            (rst_b),
        .idu_cp0_cache_vld   (vld),
        .idu_cp0_cache_op    (op),
        .idu_cp0_cache_rs1   (rs1),
        .cp0_idu_cache_rdy   (rdy),
        .cp0_dcache_req_vld  (req_vld),
        .cp0_dcache_req_type (req_type),
        .cp0_dcache_req_pa   (req_pa),
        .cp0_dcache_req_addr (req_addr),
        .dcache_cp0_req_gnt  (gnt),
        .dcache_cp0_idle     (idle),
        .cp0_icache_inv_req  (inv_req),
        .cp0_icache_inv_pa   (inv_pa),
        .icache_cp0_inv_done (done),
        .cp0_rtu_cache_cmplt (cmplt)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, required completion");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every granted request is popped and compared; cmplt pulses
    // are counted and time-stamped (cycle N+k, N = accepting edge).
    initial forever begin
        req_t got, e;
        @(negedge clk);
        if (cmplt === 1'b1) begin
            n_cmplt++;
            cmplt_cyc = cyc + 1;
        end
        if (req_vld === 1'b1 && gnt === 1'b1) begin
            got = '{t: req_type, pa: req_pa, a: req_addr};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_req: got type=%b pa=%b addr=%h, required none",
                         got.t, got.pa, got.a);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_err++;
                    $display("FAIL sb_req: got type=%b pa=%b addr=%h, required type=%b pa=%b addr=%h",
                             got.t, got.pa, got.a, e.t, e.pa, e.a);
                end
            end
        end
    end

    function automatic logic [31:0] sw(input int s, input int w);
        logic [31:0] a;
        a = '0;
        a[31]  = w[0];
        a[5:4] = s[1:0];
        return a;
    endfunction

    function automatic logic [39:0] outs();
        return {rdy, req_vld, req_type, req_pa, req_addr, inv_req, inv_pa, cmplt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [5:0] o, input logic [31:0] r, output int acc);
        vld = 1'b1;
        op  = o;
        rs1 = r;
        tick();
        vld = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_cmplt(input int c0);
        for (int i = 0; i < 60 && n_cmplt == c0; i++) tick();
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (outs() !== EXP_RST) begin
            n_err++;
            $display("FAIL reset_outs: got %h, required %h", outs(), EXP_RST);
        end
        rst_b = 1'b1;
        tick();
    endtask

    task automatic test_dc_all();
        int acc, c0;
        gnt = 1'b1;
        idle = 1'b1;
        c0 = n_cmplt;
        for (int s = 0; s < 4; s++)
            for (int w = 0; w < 2; w++) exp_q.push_back('{t: 2'b11, pa: 1'b0, a: sw(s, w)});
        accept(6'b000011, 32'hDEAD_BEEF, acc);
        wait_cmplt(c0);
        n_cmp++;
        if (n_cmplt !== c0 + 1) begin
            n_err++;
            $display("FAIL dcall_cmplt_count: got %0d, required %0d", n_cmplt - c0, 1);
        end
        n_cmp++;
        if (cmplt_cyc !== acc + 10) begin
            n_err++;
            $display("FAIL dcall_latency: got N+%0d, required N+10", cmplt_cyc - acc);
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL dcall_req_count: got %0d left over, required 0", exp_q.size());
            exp_q.delete();
        end
        n_cmp++;
        if (rdy !== 1'b1) begin
            n_err++;
            $display("FAIL dcall_rdy_after: got %b, required 1", rdy);
        end
    endtask

    task automatic test_dc_one_stall();
        int acc, c0;
        gnt = 1'b0;
        idle = 1'b0;
        c0 = n_cmplt;
        exp_q.push_back('{t: 2'b01, pa: 1'b1, a: 32'h8000_1230});
        accept(6'b101001, 32'h8000_1230, acc);
        for (int i = 1; i <= 5; i++) begin
            n_cmp++;
            if ({req_vld, req_type, req_pa, req_addr} !== {1'b1, 2'b01, 1'b1, 32'h8000_1230}) begin
                n_err++;
                $display("FAIL cpa_stall_c%0d: got vld=%b type=%b pa=%b addr=%h, required 1/01/1/80001230",
                         i, req_vld, req_type, req_pa, req_addr);
            end
            tick();
        end
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        tick();
        n_cmp++;
        if ({req_vld, cmplt} !== 2'b00) begin
            n_err++;
            $display("FAIL cpa_wait_idle: got vld=%b cmplt=%b, required 0/0", req_vld, cmplt);
        end
        idle = 1'b1;
        tick();
        n_cmp++;
        if (cmplt !== 1'b1) begin
            n_err++;
            $display("FAIL cpa_cmplt: got %b, required 1", cmplt);
        end
        tick();
        n_cmp++;
        if (n_cmplt !== c0 + 1 || cmplt_cyc !== acc + 9) begin
            n_err++;
            $display("FAIL cpa_cmplt_timing: got count=%0d at N+%0d, required 1 at N+9",
                     n_cmplt - c0, cmplt_cyc - acc);
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL cpa_req_count: got %0d left over, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_icache();
        int acc, c0;
        gnt = 1'b1;
        idle = 1'b1;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        n_cmp++;
        if ({rdy, inv_req, cmplt} !== 3'b100) begin
            n_err++;
            $display("FAIL ic_stray_done: got rdy/inv/cmplt=%b, required 100", {rdy, inv_req, cmplt});
        end
        c0 = n_cmplt;
        accept(6'b111000, 32'h0000_0400, acc);
        for (int i = 1; i <= 4; i++) begin
            n_cmp++;
            if ({req_vld, inv_req, inv_pa, req_addr} !== {1'b0, 1'b1, 1'b1, 32'h0000_0400}) begin
                n_err++;
                $display("FAIL ic_ipa_c%0d: got vld=%b inv=%b ipa=%b addr=%h, required 0/1/1/00000400",
                         i, req_vld, inv_req, inv_pa, req_addr);
            end
            if (i == 4) done = 1'b1;
            tick();
        end
        done = 1'b0;
        n_cmp++;
        if ({cmplt, inv_req, req_vld} !== 3'b100) begin
            n_err++;
            $display("FAIL ic_cmplt: got cmplt/inv/vld=%b, required 100", {cmplt, inv_req, req_vld});
        end
        tick();
        n_cmp++;
        if (n_cmplt !== c0 + 1 || cmplt_cyc !== acc + 5) begin
            n_err++;
            $display("FAIL ic_cmplt_timing: got count=%0d at N+%0d, required 1 at N+5",
                     n_cmplt - c0, cmplt_cyc - acc);
        end
    endtask

    task automatic test_noop();
        int acc;
        gnt = 1'b1;
        accept(6'b011000, 32'hFFFF_FFFF, acc);
        n_cmp++;
        if ({rdy, cmplt, req_vld, inv_req} !== 4'b0100) begin
            n_err++;
            $display("FAIL sync_n1: got rdy/cmplt/vld/inv=%b, required 0100",
                     {rdy, cmplt, req_vld, inv_req});
        end
        tick();
        n_cmp++;
        if ({rdy, cmplt} !== 2'b10) begin
            n_err++;
            $display("FAIL sync_n2: got rdy/cmplt=%b, required 10", {rdy, cmplt});
        end
    endtask

    task automatic test_reset_mid_op();
        int acc, c0;
        gnt = 1'b1;
        idle = 1'b1;
        exp_q.push_back('{t: 2'b10, pa: 1'b0, a: sw(0, 0)});
        exp_q.push_back('{t: 2'b10, pa: 1'b0, a: sw(0, 1)});
        exp_q.push_back('{t: 2'b10, pa: 1'b0, a: sw(1, 0)});
        accept(6'b000010, 32'h0, acc);
        tick();
        tick();
        tick();
        gnt = 1'b0;
        rst_b = 1'b0;
        c0 = n_cmplt;
        tick();
        n_cmp++;
        if (outs() !== EXP_RST) begin
            n_err++;
            $display("FAIL midrst_outs: got %h, required %h", outs(), EXP_RST);
        end
        rst_b = 1'b1;
        tick();
        tick();
        tick();
        n_cmp++;
        if (n_cmplt !== c0 || exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL midrst_no_cmplt: got cmplt=%0d leftover=%0d, required 0/0",
                     n_cmplt - c0, exp_q.size());
            exp_q.delete();
        end
        // Set/way op after the reset; stray rs1 bits must be masked off.
        gnt = 1'b1;
        c0 = n_cmplt;
        exp_q.push_back('{t: 2'b11, pa: 1'b0, a: 32'h8000_0020});
        accept(6'b100011, 32'h8000_0F2F, acc);
        wait_cmplt(c0);
        n_cmp++;
        if (n_cmplt !== c0 + 1 || cmplt_cyc !== acc + 3) begin
            n_err++;
            $display("FAIL cisw_after_rst: got count=%0d at N+%0d, required 1 at N+3",
                     n_cmplt - c0, cmplt_cyc - acc);
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL cisw_req_count: got %0d left over, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_busy_vld();
        int acc, c0;
        gnt = 1'b1;
        idle = 1'b1;
        c0 = n_cmplt;
        for (int s = 0; s < 4; s++)
            for (int w = 0; w < 2; w++) exp_q.push_back('{t: 2'b01, pa: 1'b0, a: sw(s, w)});
        accept(6'b000001, 32'h0, acc);
        vld = 1'b1;
        op  = 6'b111000;
        rs1 = 32'h1234_5670;
        for (int i = 1; i <= 8; i++) begin
            n_cmp++;
            if ({rdy, inv_req, req_vld} !== 3'b001) begin
                n_err++;
                $display("FAIL busy_c%0d: got rdy/inv/vld=%b, required 001", i, {rdy, inv_req, req_vld});
            end
            tick();
        end
        vld = 1'b0;
        wait_cmplt(c0);
        n_cmp++;
        if (n_cmplt !== c0 + 1 || cmplt_cyc !== acc + 10) begin
            n_err++;
            $display("FAIL busy_cmplt: got count=%0d at N+%0d, required 1 at N+10",
                     n_cmplt - c0, cmplt_cyc - acc);
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL busy_req_count: got %0d left over, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rst_b = 1'b0;
        vld   = 1'b0;
        op    = '0;
        rs1   = '0;
        gnt   = 1'b0;
        idle  = 1'b1;
        done  = 1'b0;
        test_reset();
        test_dc_all();
        test_dc_one_stall();
        test_icache();
        test_noop();
        test_reset_mid_op();
        test_busy_vld();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pa_cp0_cache_seq.md
# pa_cp0_cache_seq

CP0 cache-maintenance sequencer, directly downstream of the IDU custom-extension decoder. It accepts one decoded cache-op instruction with the CP0 select, which covers the dcache/icache all, set/way and physical-address variants. For each op it issues single-line requests to the D-cache or one invalidate request to the I-cache, and walks every set/way for the "all" variants. When the cache reports idle, it signals completion to the RTU. Ops that are not cache ops (sync, sync.i, unimplemented) complete as no-ops.

## Interface
- SET_W, 7, set index width; 2^SET_W sets.
- WAY_NUM, 2, D-cache ways, 1..4.
- LINE_OFF, 4, line-offset bits; the set field of rs1 is rs1[SET_W+LINE_OFF-1:LINE_OFF].

Ports. One clock. Reset is synchronous and active-low.
- forever_cpuclk  in  1  clock
- cpurst_b  in  1  synchronous active-low reset
- idu_cp0_cache_vld  in  1  op valid
- idu_cp0_cache_op  in  6  {inst[25], inst[24:20]}
- idu_cp0_cache_rs1  in  32  rs1 operand: PA, or {way@[31], set field}
- cp0_idu_cache_rdy  out  1  sequencer idle, can accept
- cp0_dcache_req_vld  out  1  D-cache line request
- cp0_dcache_req_type  out  2  01 clean, 10 invalidate, 11 clean+invalidate
- cp0_dcache_req_pa  out  1  1: addr is PA; 0: set/way
- cp0_dcache_req_addr  out  32  PA, or {way@[31], set@[SET_W+LINE_OFF-1:LINE_OFF], 0 elsewhere}
- dcache_cp0_req_gnt  in  1  request accepted this cycle
- dcache_cp0_idle  in  1  all outstanding line ops retired
- cp0_icache_inv_req  out  1  I-cache invalidate request; level signal
- cp0_icache_inv_pa  out  1  1: single PA (uses cp0_dcache_req_addr); 0: all
- icache_cp0_inv_done  in  1  one-cycle done pulse
- cp0_rtu_cache_cmplt  out  1  one-cycle completion pulse

## Operation
- Accept when idu_cp0_cache_vld & cp0_idu_cache_rdy. On acceptance, op and rs1 are registered; inputs are ignored while busy.
- Op decode and the resulting next state:
  - 0_000tt (dcache.call/iall/ciall, tt≠00) goes to DC_ALL with type=tt.
  - 1_000tt (csw/isw/cisw) goes to DC_ONE with pa=0 and addr built from the rs1 way/set fields.
  - 1_010tt (cpa/ipa/cipa) goes to DC_ONE with pa=1 and addr=rs1.
  - 0_1000x (icache.iall/ialls) goes to IC with pa=0.
  - 1_11000 (icache.ipa) goes to IC with pa=1 and addr=rs1.
  - Every other encoding goes to CMPLT directly.
- States and transitions:
  - IDLE: rdy=1. Moves on acceptance as listed above.
  - DC_ALL: req_vld=1. Set/way counter starts at set 0, way 0; way is the inner loop. On each gnt the counter advances. The gnt on the last line (set 2^SET_W-1, way WAY_NUM-1) moves to WAIT.
  - DC_ONE: req_vld=1 until gnt, then moves to WAIT.
  - IC: inv_req=1 until icache_cp0_inv_done, then moves to CMPLT.
  - WAIT: waits for dcache_cp0_idle=1, then moves to CMPLT.
  - CMPLT: cmplt=1 for exactly one cycle, then moves to IDLE.
- Request handshake: once req_vld is asserted, it stays high and type/pa/addr stay stable until gnt. The next line is presented in the cycle after gnt, with no gap.
- The set/way counter is SET_W+log2(WAY_NUM) bits wide and is cleared on entry to DC_ALL. It never wraps while in DC_ALL.
- A done pulse with inv_req low is ignored. An idle signal outside WAIT is ignored.

## Timing
- Reset values: rdy=1. All other outputs are 0: req_vld, req_type, req_pa, req_addr, inv_req, inv_pa, cmplt. State is IDLE and the counter is 0.
- Reset asserted mid-op: at the next clock edge the block is in IDLE with all outputs at their reset values, and no cmplt is generated.
- Acceptance at edge N: the first request (or cmplt, for no-op encodings) is visible in cycle N+1.
- Latency with gnt tied high and idle high:
  - DC_ALL: cmplt appears at N+2^SET_W·WAY_NUM+2.
  - DC_ONE: cmplt appears at N+3.
  - No-op: cmplt appears at N+1.
- Accept-to-accept: rdy rises in the cycle after cmplt, so back-to-back ops are spaced by at least one cmplt cycle.

## Structure
- A shared define header holds the state encodings, the req_type codes (CLR, INV, CLRINV) and the op-field encodings. The IDU decoder uses the same header.
- One sub-module, pa_cp0_cache_seq_cnt, contains the set/way counter with clear, advance and last flag.
- The top level contains the FSM, the request registers and the op decode.

## Test plan
- dcache.ciall (op=0_00011), SET_W=2, WAY_NUM=2, gnt always 1 → 8 requests with addr set/way sequence (s0w0, s0w1, s1w0, …, s3w1) and type=11. After idle=1, one cmplt pulse appears at N+10.
- dcache.cpa (1_01001), rs1=0x8000_1230, gnt held low for 5 cycles → req_vld/addr/type=01 stay stable for 5 cycles. cmplt follows after gnt and idle.
- icache.ipa (1_11000), rs1=0x0000_0400, done after 4 cycles → inv_req=1 and inv_pa=1 for 4 cycles with addr=0x400. cmplt appears in the cycle after done, and req_vld stays 0 throughout.
- sync (0_11000) → no request is issued. cmplt appears at N+1 and rdy returns at N+2.
- DC_ALL with cpurst_b pulled low after the 3rd gnt → the following cycle shows rdy=1, all outputs 0 and no cmplt. A new op is then accepted normally.
- vld asserted while busy with a different op → the op is not accepted, and the current op's addr sequence is unaffected.
